// File: rtl/pal576i_pkg.sv
// Shared PAL 576i line structure: half-line pulse types and frame line constants.
// Pure declarations: no latency, no backpressure.
package pal576i_pkg;

   typedef enum logic [1:0] {
      HL_NONE,
      HL_NORMAL,
      HL_EQ,
      HL_BROAD
   } halfline_t;

   localparam logic [9:0] LINES_PER_FRAME = 10'd625;
   localparam logic [9:0] FIELD1_LAST     = 10'd312;
   localparam logic [9:0] FIELD2_FIRST    = 10'd313;
   localparam logic [9:0] ACT1_FIRST      = 10'd23;
   localparam logic [9:0] ACT1_LAST       = 10'd310;
   localparam logic [9:0] ACT2_FIRST      = 10'd336;
   localparam logic [9:0] ACT2_LAST       = 10'd623;

endpackage

// File: rtl/pal576i_halfline_decoder.sv
// Maps a frame line number to the sync pulse type of its two half lines.
// Purely combinational (zero latency), no backpressure.
module pal576i_halfline_decoder
   import pal576i_pkg::*;
(
   input  logic [9:0] line_cnt,
   output halfline_t  first_half,
   output halfline_t  second_half
);

   always_comb begin
      first_half  = HL_NORMAL;
      second_half = HL_NONE;
      case (line_cnt)
         10'd1, 10'd2, 10'd314, 10'd315: begin
            first_half  = HL_BROAD;
            second_half = HL_BROAD;
         end
         10'd3: begin
            first_half  = HL_BROAD;
            second_half = HL_EQ;
         end
         10'd4, 10'd5, 10'd311, 10'd312, 10'd316, 10'd317, 10'd624, 10'd625: begin
            first_half  = HL_EQ;
            second_half = HL_EQ;
         end
         10'd313: begin
            first_half  = HL_EQ;
            second_half = HL_BROAD;
         end
         10'd318: begin
            first_half  = HL_EQ;
            second_half = HL_NONE;
         end
         10'd623: begin
            first_half  = HL_NORMAL;
            second_half = HL_EQ;
         end
         default: begin
            first_half  = HL_NORMAL;
            second_half = HL_NONE;
         end
      endcase
   end

endmodule

// File: rtl/csync_generator_pal576i.sv
// PAL 576i timing master: composite/h/v sync, field parity, pixel coordinates, gated RGB111.
// Coordinates register on the tick; syncs and rgb_111 follow one tick later. No backpressure: free-running.
module csync_generator_pal576i
   import pal576i_pkg::*;
#(
   parameter logic [2:0] TICK_PHASE     = 3'd0,
   parameter int         LINE_TICKS     = 864,
   parameter int         HSYNC_TICKS    = 64,
   parameter int         EQ_TICKS       = 32,
   parameter int         BROAD_TICKS    = 368,
   parameter int         H_ACTIVE_START = 132,
   parameter int         H_ACTIVE_WIDTH = 720
) (
   input  logic       sysClk,
   input  logic       reset,
   input  logic [2:0] sysClkPhase,
   input  logic [2:0] rgb_111_in,
   output logic       csync,
   output logic       hsync,
   output logic       vsync,
   output logic       isFieldOdd,
   output logic [9:0] pixelX,
   output logic [9:0] pixelY,
   output logic       displayEnable,
   output logic       frame_start_flag,
   output logic [2:0] rgb_111
);

   localparam logic [9:0] LINE_LAST = 10'(LINE_TICKS - 1);
   localparam logic [9:0] HALF_W    = 10'(LINE_TICKS / 2);
   localparam logic [9:0] HS_W      = 10'(HSYNC_TICKS);
   localparam logic [9:0] EQ_W      = 10'(EQ_TICKS);
   localparam logic [9:0] BR_W      = 10'(BROAD_TICKS);
   localparam logic [9:0] H_START   = 10'(H_ACTIVE_START);
   localparam logic [9:0] H_END     = 10'(H_ACTIVE_START + H_ACTIVE_WIDTH - 1);

   logic       tick;
   logic [9:0] tick_cnt;
   logic [9:0] line_cnt;
   halfline_t  first_half;
   halfline_t  second_half;
   halfline_t  cur_hl;
   logic       in_second;
   logic [9:0] half_off;
   logic [9:0] pulse_w;
   logic       csync_low;
   logic       hsync_low;
   logic       vsync_low;
   logic       field1_act;
   logic       field2_act;
   logic       active;
   logic [9:0] y_calc;
   logic       csync_d;
   logic       hsync_d;
   logic       vsync_d;

   assign tick = (sysClkPhase == TICK_PHASE);

   // tick_cnt/line_cnt name the position that the next tick will emit.
   always_ff @(posedge sysClk or posedge reset) begin
      if (reset) begin
         tick_cnt <= '0;
         line_cnt <= 10'd1;
      end else if (tick) begin
         if (tick_cnt == LINE_LAST) begin
            tick_cnt <= '0;
            line_cnt <= (line_cnt == LINES_PER_FRAME) ? 10'd1 : line_cnt + 10'd1;
         end else begin
            tick_cnt <= tick_cnt + 10'd1;
         end
      end
   end

   pal576i_halfline_decoder u_halfline_decoder (
      .line_cnt    (line_cnt),
      .first_half  (first_half),
      .second_half (second_half)
   );

   always_comb begin
      in_second = (tick_cnt >= HALF_W);
      half_off  = in_second ? tick_cnt - HALF_W : tick_cnt;
      cur_hl    = in_second ? second_half : first_half;
      pulse_w   = '0;
      case (cur_hl)
         HL_NORMAL: pulse_w = HS_W;
         HL_EQ:     pulse_w = EQ_W;
         HL_BROAD:  pulse_w = BR_W;
         default:   pulse_w = '0;
      endcase
      csync_low = (half_off < pulse_w);
      hsync_low = (tick_cnt < HS_W);
      // Field 1 vsync spans 2.5 lines from line 1; field 2 starts mid line 313.
      vsync_low = (line_cnt < 10'd3)
               || (line_cnt == 10'd3 && !in_second)
               || (line_cnt == FIELD2_FIRST && in_second)
               || (line_cnt == 10'd314)
               || (line_cnt == 10'd315);
   end

   always_comb begin
      field1_act = (line_cnt >= ACT1_FIRST) && (line_cnt <= ACT1_LAST);
      field2_act = (line_cnt >= ACT2_FIRST) && (line_cnt <= ACT2_LAST);
      active     = (field1_act || field2_act) && (tick_cnt >= H_START) && (tick_cnt <= H_END);
      y_calc     = field1_act ? (line_cnt - ACT1_FIRST) << 1
                              : ((line_cnt - ACT2_FIRST) << 1) | 10'd1;
   end

   always_ff @(posedge sysClk or posedge reset) begin
      if (reset) begin
         pixelX           <= '0;
         pixelY           <= '0;
         displayEnable    <= 1'b0;
         frame_start_flag <= 1'b0;
         isFieldOdd       <= 1'b1;
         csync_d          <= 1'b1;
         hsync_d          <= 1'b1;
         vsync_d          <= 1'b1;
      end else if (tick) begin
         pixelX           <= active ? tick_cnt - H_START : '0;
         pixelY           <= active ? y_calc : '0;
         displayEnable    <= active;
         frame_start_flag <= (line_cnt == 10'd1) && (tick_cnt == '0);
         isFieldOdd       <= (line_cnt <= FIELD1_LAST);
         csync_d          <= !csync_low;
         hsync_d          <= !hsync_low;
         vsync_d          <= !vsync_low;
      end
   end

   // Second stage gives the pixel source one tick to answer the coordinates.
   always_ff @(posedge sysClk or posedge reset) begin
      if (reset) begin
         csync   <= 1'b1;
         hsync   <= 1'b1;
         vsync   <= 1'b1;
         rgb_111 <= '0;
      end else if (tick) begin
         csync   <= csync_d;
         hsync   <= hsync_d;
         vsync   <= vsync_d;
         rgb_111 <= displayEnable ? rgb_111_in : 3'b000;
      end
   end

endmodule

// File: tb/tb_csync_generator_pal576i.sv
// Bench for csync_generator_pal576i: full-size instance plus a shortened-line instance that
// covers a whole frame; both are compared every cycle to a position-based model and to a vector table.
module tb_csync_generator_pal576i;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       de;
      logic       fs;
      logic       odd;
      logic       cs;
      logic       hs;
      logic       vs;
      logic [2:0] rgb;
   } out_t;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       de;
      logic       fs;
      logic       odd;
   } crd_t;

   typedef struct {
      int L;
      int hs;
      int eq;
      int br;
      int has;
      int haw;
   } prm_t;

   typedef struct {
      int inst;
      int line;
      int tick;
      int fld;
      int exp;
   } vec_t;

   localparam int F_X = 0, F_Y = 1, F_DE = 2, F_FS = 3, F_ODD = 4, F_CS = 5, F_HS = 6, F_VS = 7;
   localparam int NOBS = 40100;
   localparam out_t RST_VAL = '{x: 10'd0, y: 10'd0, de: 1'b0, fs: 1'b0, odd: 1'b1,
                                cs: 1'b1, hs: 1'b1, vs: 1'b1, rgb: 3'b000};

   logic       sysClk = 1'b0;
   logic       rst;
   logic [2:0] phase;
   logic [2:0] rgb_in;

   logic       cs0, hs0, vs0, odd0, de0, fs0, cs1, hs1, vs1, odd1, de1, fs1;
   logic [9:0] x0, y0, x1, y1;
   logic [2:0] rgb0, rgb1;
   out_t       act [2];

   int         checks = 0;
   int         errors = 0;
   int         k;
   bit         tick_now;
   bit         rec;
   logic [2:0] last_rgb;
   prm_t       P [2];
   vec_t       tbl [$];
   int         fsq [$];
   crd_t       obs_c [2][NOBS];
   logic [2:0] obs_s [2][NOBS];

   always #5 sysClk = ~sysClk;

   csync_generator_pal576i u_full (
      .sysClk (sysClk), .reset (rst), .sysClkPhase (phase), .rgb_111_in (rgb_in),
      .csync (cs0), .hsync (hs0), .vsync (vs0), .isFieldOdd (odd0),
      .pixelX (x0), .pixelY (y0), .displayEnable (de0), .frame_start_flag (fs0),
      .rgb_111 (rgb0)
   );

   csync_generator_pal576i #(
      .TICK_PHASE (3'd0), .LINE_TICKS (64), .HSYNC_TICKS (6), .EQ_TICKS (3),
      .BROAD_TICKS (26), .H_ACTIVE_START (10), .H_ACTIVE_WIDTH (50)
   ) u_short (
      .sysClk (sysClk), .reset (rst), .sysClkPhase (phase), .rgb_111_in (rgb_in),
      .csync (cs1), .hsync (hs1), .vsync (vs1), .isFieldOdd (odd1),
      .pixelX (x1), .pixelY (y1), .displayEnable (de1), .frame_start_flag (fs1),
      .rgb_111 (rgb1)
   );

   assign act[0] = '{x: x0, y: y0, de: de0, fs: fs0, odd: odd0, cs: cs0, hs: hs0, vs: vs0, rgb: rgb0};
   assign act[1] = '{x: x1, y: y1, de: de1, fs: fs1, odd: odd1, cs: cs1, hs: hs1, vs: vs1, rgb: rgb1};

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   function automatic string hl_code(input int line);
      if (line == 1 || line == 2 || line == 314 || line == 315) return "BB";
      if (line == 3) return "BE";
      if (line == 4 || line == 5 || line == 311 || line == 312 || line == 316 ||
          line == 317 || line == 624 || line == 625) return "EE";
      if (line == 313) return "EB";
      if (line == 318) return "E-";
      if (line == 623) return "NE";
      return "N-";
   endfunction

   // Everything the design should show for absolute tick position pos (0 = line 1, tick 0).
   function automatic out_t model(input prm_t p, input int pos);
      out_t  o;
      string code;
      byte   c;
      int    line, t, half, off, w, hl;
      bit    sec, f1, f2, a;
      line = (pos / p.L) % 625 + 1;
      t    = pos % p.L;
      half = p.L / 2;
      sec  = (t >= half);
      off  = sec ? t - half : t;
      hl   = 2 * (line - 1) + (sec ? 1 : 0);
      code = hl_code(line);
      c    = sec ? code[1] : code[0];
      case (c)
         "N":     w = p.hs;
         "E":     w = p.eq;
         "B":     w = p.br;
         default: w = 0;
      endcase
      f1 = (line >= 23 && line <= 310);
      f2 = (line >= 336 && line <= 623);
      a  = (f1 || f2) && t >= p.has && t < p.has + p.haw;
      o     = '0;
      o.cs  = !(off < w);
      o.hs  = !(t < p.hs);
      o.vs  = !(hl <= 4 || (hl >= 625 && hl <= 629));
      o.odd = (line <= 312);
      o.fs  = (line == 1 && t == 0);
      o.de  = a;
      o.x   = a ? 10'(t - p.has) : 10'd0;
      o.y   = !a ? 10'd0 : (f1 ? 10'(2 * (line - 23)) : 10'(2 * (line - 336) + 1));
      return o;
   endfunction

   function automatic out_t expect_now(input int i);
      out_t e, c, s;
      e = RST_VAL;
      if (!rst && k >= 1) begin
         c = model(P[i], k - 1);
         e.x = c.x; e.y = c.y; e.de = c.de; e.fs = c.fs; e.odd = c.odd;
      end
      if (!rst && k >= 2) begin
         s = model(P[i], k - 2);
         e.cs = s.cs; e.hs = s.hs; e.vs = s.vs;
         e.rgb = s.de ? last_rgb : 3'b000;
      end
      return e;
   endfunction

   task automatic check_all();
      for (int i = 0; i < 2; i++)
         chk($sformatf("model inst%0d k%0d", i, k), 64'(act[i]), 64'(expect_now(i)));
   endtask

   task automatic record();
      if (!rec) return;
      for (int i = 0; i < 2; i++) begin
         if (k >= 1 && k <= NOBS)
            obs_c[i][k-1] = '{x: act[i].x, y: act[i].y, de: act[i].de, fs: act[i].fs, odd: act[i].odd};
         if (k >= 2 && k - 2 < NOBS)
            obs_s[i][k-2] = {act[i].cs, act[i].hs, act[i].vs};
      end
      if (tick_now && act[1].fs) fsq.push_back(k - 1);
   endtask

   // Called at a falling edge: drive inputs, let one rising edge pass, then check.
   task automatic cycle(input logic [2:0] ph);
      phase  = ph;
      rgb_in = 3'($urandom);
      @(posedge sysClk);
      tick_now = (ph == 3'd0) && !rst;
      @(negedge sysClk);
      if (rst) k = 0;
      else if (tick_now) begin
         k++;
         last_rgb = rgb_in;
      end
      check_all();
      record();
   endtask

   function automatic int fetch(input int inst, input int pos, input int fld);
      crd_t       c;
      logic [2:0] s;
      c = obs_c[inst][pos];
      s = obs_s[inst][pos];
      case (fld)
         F_X:     return int'(c.x);
         F_Y:     return int'(c.y);
         F_DE:    return int'(c.de);
         F_FS:    return int'(c.fs);
         F_ODD:   return int'(c.odd);
         F_CS:    return int'(s[2]);
         F_HS:    return int'(s[1]);
         default: return int'(s[0]);
      endcase
   endfunction

   initial begin
      int pos;
      P[0] = '{864, 64, 32, 368, 132, 720};
      P[1] = '{64, 6, 3, 26, 10, 50};

      // Full-size timing, first 40 lines
      tbl.push_back('{0, 1, 0, F_FS, 1});     tbl.push_back('{0, 1, 1, F_FS, 0});
      tbl.push_back('{0, 1, 0, F_CS, 0});     tbl.push_back('{0, 1, 0, F_VS, 0});
      tbl.push_back('{0, 1, 0, F_HS, 0});     tbl.push_back('{0, 1, 367, F_CS, 0});
      tbl.push_back('{0, 1, 368, F_CS, 1});   tbl.push_back('{0, 1, 432, F_CS, 0});
      tbl.push_back('{0, 1, 799, F_CS, 0});   tbl.push_back('{0, 1, 800, F_CS, 1});
      tbl.push_back('{0, 3, 431, F_VS, 0});   tbl.push_back('{0, 3, 432, F_VS, 1});
      tbl.push_back('{0, 3, 432, F_CS, 0});   tbl.push_back('{0, 3, 463, F_CS, 0});
      tbl.push_back('{0, 3, 464, F_CS, 1});   tbl.push_back('{0, 4, 31, F_CS, 0});
      tbl.push_back('{0, 4, 32, F_CS, 1});    tbl.push_back('{0, 4, 432, F_CS, 0});
      tbl.push_back('{0, 4, 464, F_CS, 1});   tbl.push_back('{0, 4, 432, F_HS, 1});
      tbl.push_back('{0, 4, 63, F_HS, 0});    tbl.push_back('{0, 22, 200, F_DE, 0});
      tbl.push_back('{0, 23, 131, F_DE, 0});  tbl.push_back('{0, 23, 132, F_DE, 1});
      tbl.push_back('{0, 23, 132, F_X, 0});   tbl.push_back('{0, 23, 132, F_Y, 0});
      tbl.push_back('{0, 23, 851, F_X, 719}); tbl.push_back('{0, 23, 852, F_DE, 0});
      tbl.push_back('{0, 24, 500, F_Y, 2});   tbl.push_back('{0, 24, 500, F_X, 368});
      tbl.push_back('{0, 40, 63, F_CS, 0});   tbl.push_back('{0, 40, 64, F_CS, 1});
      tbl.push_back('{0, 40, 64, F_HS, 1});   tbl.push_back('{0, 40, 432, F_CS, 1});
      // Shortened lines (64 ticks, half 32), whole frame
      tbl.push_back('{1, 312, 0, F_ODD, 1});  tbl.push_back('{1, 313, 0, F_ODD, 0});
      tbl.push_back('{1, 313, 0, F_CS, 0});   tbl.push_back('{1, 313, 2, F_CS, 0});
      tbl.push_back('{1, 313, 3, F_CS, 1});   tbl.push_back('{1, 313, 31, F_VS, 1});
      tbl.push_back('{1, 313, 32, F_VS, 0});  tbl.push_back('{1, 313, 32, F_CS, 0});
      tbl.push_back('{1, 313, 57, F_CS, 0});  tbl.push_back('{1, 313, 58, F_CS, 1});
      tbl.push_back('{1, 318, 2, F_CS, 0});   tbl.push_back('{1, 318, 3, F_CS, 1});
      tbl.push_back('{1, 318, 32, F_CS, 1});  tbl.push_back('{1, 623, 5, F_CS, 0});
      tbl.push_back('{1, 623, 6, F_CS, 1});   tbl.push_back('{1, 623, 32, F_CS, 0});
      tbl.push_back('{1, 623, 35, F_CS, 1});  tbl.push_back('{1, 623, 10, F_Y, 575});
      tbl.push_back('{1, 623, 10, F_DE, 1});  tbl.push_back('{1, 336, 59, F_X, 49});
      tbl.push_back('{1, 336, 59, F_Y, 1});   tbl.push_back('{1, 336, 10, F_X, 0});
      tbl.push_back('{1, 310, 10, F_Y, 574}); tbl.push_back('{1, 311, 10, F_DE, 0});
      tbl.push_back('{1, 315, 63, F_VS, 0});  tbl.push_back('{1, 316, 0, F_VS, 1});
      tbl.push_back('{1, 625, 32, F_CS, 0});  tbl.push_back('{1, 625, 63, F_FS, 0});
      tbl.push_back('{1, 626, 0, F_FS, 1});

      rst = 1'b1; phase = 3'd0; rgb_in = 3'd0; last_rgb = 3'd0;
      k = 0; rec = 1'b1; tick_now = 1'b0;
      repeat (2) @(negedge sysClk);
      check_all();
      rst = 1'b0;

      // Free run just past one short-line frame, with random stalls and pixels
      while (k < NOBS)
         cycle(($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
      rec = 1'b0;

      foreach (tbl[j]) begin
         pos = (tbl[j].line - 1) * P[tbl[j].inst].L + tbl[j].tick;
         if (pos + 2 > NOBS) chk($sformatf("tbl%0d range", j), 64'(pos), 64'(NOBS - 2));
         else chk($sformatf("tbl inst%0d line%0d tick%0d fld%0d", tbl[j].inst, tbl[j].line,
                            tbl[j].tick, tbl[j].fld),
                  64'(fetch(tbl[j].inst, pos, tbl[j].fld)), 64'(tbl[j].exp));
      end
      chk("frame starts seen", 64'(fsq.size()), 64'(2));
      if (fsq.size() >= 2) chk("frame period", 64'(fsq[1] - fsq[0]), 64'(625 * 64));

      // Asynchronous reset in mid-line, away from the clock edge
      @(posedge sysClk);
      #2 rst = 1'b1;
      #1;
      chk("async reset full", 64'(act[0]), 64'(RST_VAL));
      chk("async reset short", 64'(act[1]), 64'(RST_VAL));
      @(negedge sysClk);
      k = 0;
      check_all();
      cycle(3'd0);
      cycle(3'd0);
      rst = 1'b0;
      cycle(3'd0);
      chk("post-reset fs full", 64'(fs0), 64'(1));
      chk("post-reset fs short", 64'(fs1), 64'(1));
      cycle(3'd0);
      chk("post-reset broad full", 64'(cs0), 64'(0));
      chk("post-reset broad short", 64'(cs1), 64'(0));

      // No tick phase: everything must hold
      repeat (10) cycle(3'd5);
      chk("freeze k", 64'(k), 64'(2));
      repeat (3000) cycle(3'($urandom_range(0, 1)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
